// File: rtl/ins_miss_queue.sv
// ---------------------------------------------------------------------------
// ins_miss_queue
//
// Purpose:
//   Buffers instruction-cache miss line addresses and issues them one at a
//   time to the next-level cache over a req/ack handshake. A repeat of the
//   newest queued line is merged instead of being stored again. Misses that
//   arrive while the queue is full (and nothing leaves on that edge) are
//   dropped. Issued, merged and dropped events are counted for statistics.
//
// Ports:
//   clk         system clock, all state changes on posedge
//   rst_n       synchronous active-low reset
//   flush       synchronous clear, same effect as reset
//   miss_valid  miss_addr carries a new miss line this cycle
//   miss_addr   line address of the miss (AW bits)
//   l2_req      request to next level, held until acked
//   l2_addr     line address for l2_req, stable while l2_req=1
//   l2_ack      next level accepts the current request
//   full        registered, count==DEPTH
//   empty       registered, count==0
//   count       registered, queued entries including the in-flight head
//   issued      requests acked by next level (wraps modulo 2^32)
//   merged      misses merged into the newest queued entry (wraps)
//   dropped     misses lost because the queue was full (wraps)
// ---------------------------------------------------------------------------
module ins_miss_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 26
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     miss_valid,
    input  logic [AW-1:0]            miss_addr,
    output logic                     l2_req,
    output logic [AW-1:0]            l2_addr,
    input  logic                     l2_ack,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              issued,
    output logic [31:0]              merged,
    output logic [31:0]              dropped
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            l2_req_q, l2_req_d;
    logic [AW-1:0]   l2_addr_q, l2_addr_d;
    logic [31:0]     issued_q, issued_d;
    logic [31:0]     merged_q, merged_d;
    logic [31:0]     dropped_q, dropped_d;

    logic            pop_s;
    logic            push_s;
    logic [AW-1:0]   tail_addr_s;

    // Push/merge/drop decision, FIFO bookkeeping, request FSM and flush override
    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        l2_req_d    = l2_req_q;
        l2_addr_d   = l2_addr_q;
        issued_d    = issued_q;
        merged_d    = merged_q;
        dropped_d   = dropped_q;
        push_s      = 1'b0;

        // Only an acked request in REQ leaves the queue; ack in IDLE is ignored.
        pop_s       = (state_q == ST_REQ) && l2_ack;
        // Newest entry sits just behind the write pointer.
        tail_addr_s = mem_q[wr_ptr_q - PTR_ONE];

        // Merge test wins over the full test; a full queue still accepts
        // when the head leaves on the same edge.
        if (miss_valid) begin
            if ((count_q != {CW{1'b0}}) && (miss_addr == tail_addr_s)) begin
                merged_d = merged_q + 32'd1;
            end else if ((count_q != CNT_MAX) || pop_s) begin
                push_s = 1'b1;
            end else begin
                dropped_d = dropped_q + 32'd1;
            end
        end else begin
            push_s = 1'b0;
        end

        if (push_s) begin
            mem_d[wr_ptr_q] = miss_addr;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (count_q != {CW{1'b0}}) begin
                    state_d   = ST_REQ;
                    l2_req_d  = 1'b1;
                    l2_addr_d = mem_q[rd_ptr_q];
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (pop_s) begin
                    state_d  = ST_IDLE;
                    l2_req_d = 1'b0;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    issued_d = issued_q + 32'd1;
                end else begin
                    state_d  = ST_REQ;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                l2_req_d = 1'b0;
            end
        endcase

        // Flush abandons everything, including the coincident miss and ack.
        if (flush) begin
            state_d   = ST_IDLE;
            rd_ptr_d  = {PW{1'b0}};
            wr_ptr_d  = {PW{1'b0}};
            count_d   = {CW{1'b0}};
            l2_req_d  = 1'b0;
            l2_addr_d = {AW{1'b0}};
            issued_d  = 32'd0;
            merged_d  = 32'd0;
            dropped_d = 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = {AW{1'b0}};
            end
        end else begin
            state_d = state_d;
        end

        full_d  = (count_d == CNT_MAX);
        empty_d = (count_d == {CW{1'b0}});
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_ptr_q  <= {PW{1'b0}};
            wr_ptr_q  <= {PW{1'b0}};
            count_q   <= {CW{1'b0}};
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            l2_req_q  <= 1'b0;
            l2_addr_q <= {AW{1'b0}};
            issued_q  <= 32'd0;
            merged_q  <= 32'd0;
            dropped_q <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {AW{1'b0}};
            end
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            l2_req_q  <= l2_req_d;
            l2_addr_q <= l2_addr_d;
            issued_q  <= issued_d;
            merged_q  <= merged_d;
            dropped_q <= dropped_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign l2_req  = l2_req_q;
    assign l2_addr = l2_addr_q;
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;
    assign issued  = issued_q;
    assign merged  = merged_q;
    assign dropped = dropped_q;

endmodule

// File: tb/tb_ins_miss_queue.sv
// ---------------------------------------------------------------------------
// tb_ins_miss_queue
//
// Directed self-checking bench for ins_miss_queue (DEPTH=4, AW=26).
// Inputs change #1 after posedge; outputs are sampled at that same point,
// so every check sees the state left by the preceding edge.
// ---------------------------------------------------------------------------
module tb_ins_miss_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        miss_valid;
    logic [25:0] miss_addr;
    logic        l2_req;
    logic [25:0] l2_addr;
    logic        l2_ack;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic [31:0] issued;
    logic [31:0] merged;
    logic [31:0] dropped;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [25:0] A = 26'h0000040;
    localparam logic [25:0] B = 26'h0000041;
    localparam logic [25:0] C = 26'h0000042;
    localparam logic [25:0] D = 26'h0000043;
    localparam logic [25:0] E = 26'h0000044;
    localparam logic [25:0] F = 26'h0000045;

    ins_miss_queue #(.DEPTH(4), .AW(26)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .miss_valid (miss_valid),
        .miss_addr  (miss_addr),
        .l2_req     (l2_req),
        .l2_addr    (l2_addr),
        .l2_ack     (l2_ack),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .issued     (issued),
        .merged     (merged),
        .dropped    (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [25:0] a);
        miss_valid = 1'b1;
        miss_addr  = a;
        step();
        miss_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Acks four requests in turn, checking address order and the idle gap
    task automatic drain4(input logic [25:0] e0, input logic [25:0] e1,
                          input logic [25:0] e2, input logic [25:0] e3,
                          input string tag);
        logic [25:0] exp_a [4];
        exp_a[0] = e0; exp_a[1] = e1; exp_a[2] = e2; exp_a[3] = e3;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 8 && !l2_req; k++) step();
            n_checks++;
            if (l2_req !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_req%0d: l2_req=%b expected 1 (timeout)", tag, i, l2_req);
            end
            n_checks++;
            if (l2_addr !== exp_a[i]) begin
                n_fail++;
                $display("FAIL %s_addr%0d: l2_addr=%h expected %h", tag, i, l2_addr, exp_a[i]);
            end
            l2_ack = 1'b1;
            step();
            l2_ack = 1'b0;
            n_checks++;
            if (l2_req !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_gap%0d: l2_req=%b expected 0 after ack", tag, i, l2_req);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({l2_req, l2_addr, count, empty, full, issued, merged, dropped} !==
            {1'b0, 26'd0, 3'd0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset: req=%b addr=%h cnt=%0d empty=%b full=%b iss=%0d mrg=%0d drp=%0d expected 0,0,0,1,0,0,0,0",
                     l2_req, l2_addr, count, empty, full, issued, merged, dropped);
        end
    endtask

    task automatic test_single();
        do_reset();
        push(A);
        n_checks++;
        if ({l2_req, count, empty} !== {1'b0, 3'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_push: req=%b cnt=%0d empty=%b expected 0,1,0", l2_req, count, empty);
        end
        step();
        n_checks++;
        if ({l2_req, l2_addr} !== {1'b1, A}) begin
            n_fail++;
            $display("FAIL single_req: req=%b addr=%h expected 1,%h", l2_req, l2_addr, A);
        end
        l2_ack = 1'b1;
        step();
        l2_ack = 1'b0;
        n_checks++;
        if ({l2_req, issued, empty, count} !== {1'b0, 32'd1, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL single_pop: req=%b iss=%0d empty=%b cnt=%0d expected 0,1,1,0",
                     l2_req, issued, empty, count);
        end
    endtask

    task automatic test_full_drop();
        do_reset();
        push(A); push(B); push(C); push(D); push(E);
        n_checks++;
        if ({full, dropped, count} !== {1'b1, 32'd1, 3'd4}) begin
            n_fail++;
            $display("FAIL full_drop: full=%b drp=%0d cnt=%0d expected 1,1,4", full, dropped, count);
        end
        drain4(A, B, C, D, "fifo");
        n_checks++;
        if ({issued, empty} !== {32'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL fifo_end: iss=%0d empty=%b expected 4,1", issued, empty);
        end
    endtask

    task automatic test_merge();
        do_reset();
        push(A);
        push(A);   // tail is A (and becomes the in-flight head on this edge)
        n_checks++;
        if ({merged, count} !== {32'd1, 3'd1}) begin
            n_fail++;
            $display("FAIL merge_same: mrg=%0d cnt=%0d expected 1,1", merged, count);
        end
        l2_ack = 1'b1;
        step();
        l2_ack = 1'b0;
        push(A); push(B); push(A);
        n_checks++;
        if ({merged, count} !== {32'd1, 3'd3}) begin
            n_fail++;
            $display("FAIL merge_nontail: mrg=%0d cnt=%0d expected 1,3", merged, count);
        end
    endtask

    task automatic test_push_pop_full();
        do_reset();
        push(A); push(B); push(C); push(D);
        miss_valid = 1'b1;
        miss_addr  = F;
        l2_ack     = 1'b1;
        step();
        miss_valid = 1'b0;
        l2_ack     = 1'b0;
        n_checks++;
        if ({count, dropped, issued} !== {3'd4, 32'd0, 32'd1}) begin
            n_fail++;
            $display("FAIL pushpop: cnt=%0d drp=%0d iss=%0d expected 4,0,1", count, dropped, issued);
        end
        drain4(B, C, D, F, "pushpop");
    endtask

    task automatic test_flush();
        int seen;
        do_reset();
        push(A); push(B); push(C);
        n_checks++;
        if ({l2_req, count} !== {1'b1, 3'd3}) begin
            n_fail++;
            $display("FAIL flush_pre: req=%b cnt=%0d expected 1,3", l2_req, count);
        end
        flush      = 1'b1;
        miss_valid = 1'b1;
        miss_addr  = D;
        step();
        flush      = 1'b0;
        miss_valid = 1'b0;
        n_checks++;
        if ({l2_req, count, empty, issued, merged, dropped} !==
            {1'b0, 3'd0, 1'b1, 32'd0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL flush_state: req=%b cnt=%0d empty=%b iss=%0d mrg=%0d drp=%0d expected 0,0,1,0,0,0",
                     l2_req, count, empty, issued, merged, dropped);
        end
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (l2_req) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL flush_noreq: req cycles=%0d expected 0", seen);
        end
    endtask

    task automatic test_reset_mid_req();
        push(A);
        step();
        n_checks++;
        if (l2_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: req=%b expected 1", l2_req);
        end
        rst_n  = 1'b0;
        l2_ack = 1'b1;
        step();
        rst_n  = 1'b1;
        l2_ack = 1'b0;
        n_checks++;
        if ({l2_req, l2_addr, count, empty, full, issued, merged, dropped} !==
            {1'b0, 26'd0, 3'd0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL rstmid: req=%b addr=%h cnt=%0d empty=%b full=%b iss=%0d mrg=%0d drp=%0d expected 0,0,0,1,0,0,0,0",
                     l2_req, l2_addr, count, empty, full, issued, merged, dropped);
        end
        step();
        step();
        n_checks++;
        if (l2_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_after: req=%b expected 0", l2_req);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        miss_valid = 1'b0;
        miss_addr  = 26'd0;
        l2_ack     = 1'b0;
        test_reset();
        test_single();
        test_full_drop();
        test_merge();
        test_push_pop_full();
        test_flush();
        test_reset_mid_req();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
